// File: rtl/mux4way16_pkg.sv
// Shared constants and the round-robin search function for mux4way16_arb.
package mux4way16_pkg;

  localparam int unsigned WIDTH = 16;

  // Same encoding as the DMux4Way16 select, so tags route words straight back
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  typedef struct packed {
    logic       any;
    logic [1:0] idx;
  } grant_t;

  // First valid channel after 'last', wrapping; idx holds 'last' when nothing is valid
  function automatic grant_t rr_next(input logic [1:0] last, input logic [3:0] valid);
    grant_t     g;
    logic [1:0] k;
    g.any = 1'b0;
    g.idx = last;
    for (int i = 1; i <= 4; i++) begin
      k = last + 2'(i);
      if (!g.any && valid[k]) begin
        g.any = 1'b1;
        g.idx = k;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-input round-robin grant from the last-served pointer and valid bits.
module rr_arbiter4
  import mux4way16_pkg::*;
(
  input  logic [1:0] i_last,
  input  logic [3:0] i_valid,
  output logic [1:0] o_grant,
  output logic       o_any
);

  grant_t w_g;

  always_comb begin
    w_g     = rr_next(i_last, i_valid);
    o_grant = w_g.idx;
    o_any   = w_g.any;
  end

endmodule

// File: rtl/mux4way16_arb.sv
// Round-robin gather of four channels into one registered, source-tagged stream.
// Optional sticky grant via `define MUX4WAY16_ARB_LOCK_EN (adds the lock input).
module mux4way16_arb #(
  parameter int unsigned WIDTH = mux4way16_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef MUX4WAY16_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [1:0]       sel
);

  import mux4way16_pkg::*;

  logic [WIDTH-1:0] r_out;
  logic [1:0]       r_sel;
  logic             r_out_valid;
  logic [1:0]       r_last;

  logic             w_load;
  logic [1:0]       w_rr_idx;
  logic             w_rr_any;
  logic [1:0]       w_gnt_idx;
  logic             w_gnt_any;
  logic             w_fire;
  logic [WIDTH-1:0] w_data;

  rr_arbiter4 u_rr_arbiter4 (
    .i_last  (r_last),
    .i_valid (in_valid),
    .o_grant (w_rr_idx),
    .o_any   (w_rr_any)
  );

  assign w_load = !r_out_valid || out_ready;

`ifdef MUX4WAY16_ARB_LOCK_EN
  logic r_locked;

  // A locked channel keeps the grant for as long as it stays valid
  always_comb begin
    w_gnt_idx = w_rr_idx;
    w_gnt_any = w_rr_any;
    if (r_locked && in_valid[r_last]) begin
      w_gnt_idx = r_last;
      w_gnt_any = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked <= 1'b0;
    end else if (w_fire) begin
      r_locked <= lock;
    end else if (w_load && !in_valid[r_last]) begin
      r_locked <= 1'b0;
    end
  end
`else
  always_comb begin
    w_gnt_idx = w_rr_idx;
    w_gnt_any = w_rr_any;
  end
`endif

  assign w_fire = rst_n && w_load && w_gnt_any;

  always_comb begin
    in_ready = 4'b0000;
    if (w_fire) begin
      in_ready = 4'(4'b0001 << w_gnt_idx);
    end
  end

  always_comb begin
    unique case (w_gnt_idx)
      SEL_A:   w_data = a;
      SEL_B:   w_data = b;
      SEL_C:   w_data = c;
      SEL_D:   w_data = d;
      default: w_data = a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_sel       <= SEL_A;
      r_out_valid <= 1'b0;
      r_last      <= SEL_D;
    end else if (w_load) begin
      if (w_fire) begin
        r_out       <= w_data;
        r_sel       <= w_gnt_idx;
        r_out_valid <= 1'b1;
        r_last      <= w_gnt_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign sel       = r_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux4way16_arb.sv
// Randomized and directed bench for mux4way16_arb against a cycle-level reference model.
module tb_mux4way16_arb;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b, c, d;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  sel;
  logic        lock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_out, m_sel, m_last;
  bit          m_valid, m_locked;
  int          fired;
  bit          pend[4];

  mux4way16_arb #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MUX4WAY16_ARB_LOCK_EN
    .lock      (lock),
`endif
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int chan_data(input int k);
    case (k)
      0: return int'(a);
      1: return int'(b);
      2: return int'(c);
      default: return int'(d);
    endcase
  endfunction

  function automatic int ref_grant();
`ifdef MUX4WAY16_ARB_LOCK_EN
    if (m_locked && in_valid[m_last]) return m_last;
`endif
    for (int i = 1; i <= 4; i++) begin
      int k = (m_last + i) % 4;
      if (in_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_out = 0; m_sel = 0; m_valid = 0; m_last = 3; m_locked = 0;
  endtask

  // One clock: check handshake, advance model at the edge, check registered outputs
  task automatic cycle();
    int         g;
    bit         ld;
    logic [3:0] er;
    #1;
    ld = !m_valid || out_ready;
    g  = ref_grant();
    er = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
    check_eq("in_ready", 32'(in_ready), 32'(er));
    fired = -1;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_out = chan_data(g); m_sel = g; m_valid = 1; m_last = g; fired = g;
        m_locked = lock;
      end else begin
        m_valid = 0;
        if (!in_valid[m_last]) m_locked = 0;
      end
    end
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("sel", 32'(sel), 32'(m_sel));
    check_eq("out", 32'(out), 32'(m_out));
  endtask

  initial begin
    rst_n = 1'b0; lock = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
    a = 16'h1111; b = 16'h2222; c = 16'h3333; d = 16'h4444;
    model_reset();
    #3;
    check_eq("rst_out", 32'(out), 32'h0);
    check_eq("rst_sel", 32'(sel), 32'h0);
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Fairness: a first after reset, then strict rotation
    for (int i = 0; i < 8; i++) begin
      cycle();
      check_eq("fair_sel", 32'(sel), 32'(i % 4));
    end

    // Single source
    in_valid = 4'b0100; c = 16'h0426;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check_eq("single_out", 32'(out), 32'h0426);
      check_eq("single_sel", 32'(sel), 32'h2);
    end

    // Backpressure then no-bubble replace
    in_valid = 4'b1000; d = 16'hFFFF;
    cycle();
    out_ready = 1'b0; in_valid = 4'b0010; b = 16'h1DD7;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("bp_out", 32'(out), 32'hFFFF);
      check_eq("bp_sel", 32'(sel), 32'h3);
    end
    out_ready = 1'b1;
    cycle();
    check_eq("bp_new_out", 32'(out), 32'h1DD7);
    check_eq("bp_new_sel", 32'(sel), 32'h1);

    // Drain to empty
    in_valid = 4'b0000;
    cycle();
    check_eq("drain_valid", 32'(out_valid), 32'h0);
    check_eq("drain_hold", 32'(out), 32'h1DD7);

    // Reset mid-stream
    in_valid = 4'b1111;
    cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    cycle();
    check_eq("mid_rst_first", 32'(sel), 32'h0);

`ifdef MUX4WAY16_ARB_LOCK_EN
    // b locks with lock=1, stays for three grants, releases on the lock=0 transfer
    lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("lock_hold", 32'(sel), 32'h1);
    end
    lock = 1'b0;
    cycle();
    check_eq("lock_last_b", 32'(sel), 32'h1);
    cycle();
    check_eq("lock_next_c", 32'(sel), 32'h2);
`endif

    // Random traffic; sources hold data and valid until accepted
    for (int k = 0; k < 4; k++) pend[k] = in_valid[k];
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1;
          case (k)
            0: a = 16'($urandom);
            1: b = 16'($urandom);
            2: c = 16'($urandom);
            default: d = 16'($urandom);
          endcase
        end
        in_valid[k] = pend[k];
      end
      out_ready = ($urandom_range(0, 3) != 0);
      lock = 1'($urandom_range(0, 1));
      cycle();
      if (fired >= 0) pend[fired] = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
